// File: rtl/vmacc_seq.sv
// Multi-cycle sequencer feeding the combinational vmacc_unit: reads vs2/vs1/vd groups,
// captures the MAC result and writes it back. Optional build macro: VMACC_SEQ_ALIGN_CHECK_EN.
module vmacc_seq #(
    parameter int VLEN_BITS = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_sew,
    input  logic                   cmd_lmul,
    input  logic [4:0]             cmd_vd,
    input  logic [4:0]             cmd_vs1,
    input  logic [4:0]             cmd_vs2,
    output logic                   rf_ren,
    output logic [4:0]             rf_raddr_a,
    output logic [4:0]             rf_raddr_b,
    output logic [4:0]             rf_raddr_c,
    input  logic [VLEN_BITS-1:0]   rf_rdata_a,
    input  logic [VLEN_BITS-1:0]   rf_rdata_b,
    input  logic [VLEN_BITS-1:0]   rf_rdata_c,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [VLEN_BITS-1:0]   rf_wdata,
    output logic                   mac_sew,
    output logic                   mac_lmul,
    output logic [4*VLEN_BITS-1:0] mac_vs2_bus,
    output logic [4*VLEN_BITS-1:0] mac_vs1_bus,
    output logic [4*VLEN_BITS-1:0] mac_acc_bus,
    input  logic [4*VLEN_BITS-1:0] mac_vd_bus,
    output logic                   busy,
    output logic                   done_valid,
    output logic                   done_err
);

    localparam int BUS_W = 4 * VLEN_BITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t             state_r;
    logic [1:0]         k_r;
    logic [1:0]         last_k_s;
    logic               misalign_s;
    logic [4:0]         vd_base_r;
    logic [4:0]         vs1_base_r;
    logic [4:0]         vs2_base_r;
    logic               cap_valid_r;
    logic [1:0]         cap_slot_r;
    logic [BUS_W-1:0]   res_buf_r;

    logic                 cmd_ready_r;
    logic                 rf_ren_r;
    logic [4:0]           rf_raddr_a_r;
    logic [4:0]           rf_raddr_b_r;
    logic [4:0]           rf_raddr_c_r;
    logic                 rf_we_r;
    logic [4:0]           rf_waddr_r;
    logic [VLEN_BITS-1:0] rf_wdata_r;
    logic                 mac_sew_r;
    logic                 mac_lmul_r;
    logic [BUS_W-1:0]     mac_vs2_bus_r;
    logic [BUS_W-1:0]     mac_vs1_bus_r;
    logic [BUS_W-1:0]     mac_acc_bus_r;
    logic                 busy_r;
    logic                 done_valid_r;
    logic                 done_err_r;

    // Extract one register-wide slot from a group-wide bus.
    function automatic logic [VLEN_BITS-1:0] slot_of(input logic [BUS_W-1:0] bus,
                                                     input logic [1:0] idx);
        return bus[32'(idx) * VLEN_BITS +: VLEN_BITS];
    endfunction

    // Final register index of the current group.
    always_comb begin
        last_k_s = 2'd0;
        if (mac_lmul_r) begin
            last_k_s = 2'd3;
        end else begin
            last_k_s = 2'd0;
        end
    end

    // Group alignment check applied to incoming commands.
    always_comb begin
        misalign_s = 1'b0;
`ifdef VMACC_SEQ_ALIGN_CHECK_EN
        if (cmd_lmul && ((cmd_vd[1:0] | cmd_vs1[1:0] | cmd_vs2[1:0]) != 2'b00)) begin
            misalign_s = 1'b1;
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
    end

    // Sequencer FSM, operand capture and result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            k_r           <= 2'd0;
            vd_base_r     <= 5'd0;
            vs1_base_r    <= 5'd0;
            vs2_base_r    <= 5'd0;
            cap_valid_r   <= 1'b0;
            cap_slot_r    <= 2'd0;
            res_buf_r     <= '0;
            cmd_ready_r   <= 1'b1;
            rf_ren_r      <= 1'b0;
            rf_raddr_a_r  <= 5'd0;
            rf_raddr_b_r  <= 5'd0;
            rf_raddr_c_r  <= 5'd0;
            rf_we_r       <= 1'b0;
            rf_waddr_r    <= 5'd0;
            rf_wdata_r    <= '0;
            mac_sew_r     <= 1'b0;
            mac_lmul_r    <= 1'b0;
            mac_vs2_bus_r <= '0;
            mac_vs1_bus_r <= '0;
            mac_acc_bus_r <= '0;
            busy_r        <= 1'b0;
            done_valid_r  <= 1'b0;
            done_err_r    <= 1'b0;
        end else begin
            // Read data arrives one cycle after its strobe; land it in the issuing slot.
            cap_valid_r <= 1'b0;
            if (cap_valid_r) begin
                mac_vs2_bus_r[32'(cap_slot_r) * VLEN_BITS +: VLEN_BITS] <= rf_rdata_a;
                mac_vs1_bus_r[32'(cap_slot_r) * VLEN_BITS +: VLEN_BITS] <= rf_rdata_b;
                mac_acc_bus_r[32'(cap_slot_r) * VLEN_BITS +: VLEN_BITS] <= rf_rdata_c;
            end

            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mac_sew_r     <= cmd_sew;
                        mac_lmul_r    <= cmd_lmul;
                        vd_base_r     <= cmd_vd;
                        vs1_base_r    <= cmd_vs1;
                        vs2_base_r    <= cmd_vs2;
                        mac_vs2_bus_r <= '0;
                        mac_vs1_bus_r <= '0;
                        mac_acc_bus_r <= '0;
                        res_buf_r     <= '0;
                        k_r           <= 2'd0;
                        cmd_ready_r   <= 1'b0;
                        busy_r        <= 1'b1;
                        if (misalign_s) begin
                            state_r      <= ST_DONE;
                            done_valid_r <= 1'b1;
                            done_err_r   <= 1'b1;
                        end else begin
                            state_r      <= ST_READ;
                            rf_ren_r     <= 1'b1;
                            rf_raddr_a_r <= cmd_vs2;
                            rf_raddr_b_r <= cmd_vs1;
                            rf_raddr_c_r <= cmd_vd;
                        end
                    end
                end
                ST_READ: begin
                    cap_valid_r <= 1'b1;
                    cap_slot_r  <= k_r;
                    if (k_r == last_k_s) begin
                        rf_ren_r <= 1'b0;
                        state_r  <= ST_WAIT;
                    end else begin
                        k_r          <= k_r + 2'd1;
                        rf_raddr_a_r <= vs2_base_r + {3'b000, k_r} + 5'd1;
                        rf_raddr_b_r <= vs1_base_r + {3'b000, k_r} + 5'd1;
                        rf_raddr_c_r <= vd_base_r + {3'b000, k_r} + 5'd1;
                    end
                end
                ST_WAIT: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Slot 0 goes out directly so the first write needs no extra cycle.
                    res_buf_r  <= mac_vd_bus;
                    rf_we_r    <= 1'b1;
                    rf_waddr_r <= vd_base_r;
                    rf_wdata_r <= mac_vd_bus[VLEN_BITS-1:0];
                    k_r        <= 2'd0;
                    state_r    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (k_r == last_k_s) begin
                        rf_we_r      <= 1'b0;
                        done_valid_r <= 1'b1;
                        done_err_r   <= 1'b0;
                        state_r      <= ST_DONE;
                    end else begin
                        k_r        <= k_r + 2'd1;
                        rf_waddr_r <= vd_base_r + {3'b000, k_r} + 5'd1;
                        rf_wdata_r <= slot_of(res_buf_r, k_r + 2'd1);
                    end
                end
                ST_DONE: begin
                    done_valid_r <= 1'b0;
                    done_err_r   <= 1'b0;
                    cmd_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    rf_ren_r     <= 1'b0;
                    rf_we_r      <= 1'b0;
                    done_valid_r <= 1'b0;
                    done_err_r   <= 1'b0;
                    cmd_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign rf_ren      = rf_ren_r;
    assign rf_raddr_a  = rf_raddr_a_r;
    assign rf_raddr_b  = rf_raddr_b_r;
    assign rf_raddr_c  = rf_raddr_c_r;
    assign rf_we       = rf_we_r;
    assign rf_waddr    = rf_waddr_r;
    assign rf_wdata    = rf_wdata_r;
    assign mac_sew     = mac_sew_r;
    assign mac_lmul    = mac_lmul_r;
    assign mac_vs2_bus = mac_vs2_bus_r;
    assign mac_vs1_bus = mac_vs1_bus_r;
    assign mac_acc_bus = mac_acc_bus_r;
    assign busy        = busy_r;
    assign done_valid  = done_valid_r;
    assign done_err    = done_err_r;

endmodule
